// File: rtl/c499_pkg.sv
// Shared constants, codeword/stage types and a reference check-bit function
// for the c499 SEC encoder.
package c499_pkg;

  localparam int DATA_W = 32;
  localparam int CHK_W  = 8;
  localparam int CW_W   = 40;

  // Data bits covered by each check bit; CHK_MASK[k] belongs to check[k].
  localparam logic [CHK_W-1:0][DATA_W-1:0] CHK_MASK = {
    32'h8888_F0F0,  // c7
    32'h4444_0F0F,  // c6
    32'h2222_FF00,  // c5
    32'h1111_00FF,  // c4
    32'hF0F0_8888,  // c3
    32'h0F0F_4444,  // c2
    32'hFF00_2222,  // c1
    32'h00FF_1111   // c0
  };

  typedef struct packed {
    logic [CHK_W-1:0]  check;
    logic [DATA_W-1:0] data;
  } cw_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              inj_en;
    logic [5:0]        inj_pos;
    logic [7:0]        nib;
    logic [7:0]        col;
  } s1_t;

  function automatic logic [CHK_W-1:0] chk_calc(input logic [DATA_W-1:0] data);
    logic [CHK_W-1:0] r;
    for (int k = 0; k < CHK_W; k++) r[k] = ^(data & CHK_MASK[k]);
    return r;
  endfunction

endpackage

// File: rtl/c499_secenc_stream_if.sv
// Input word / output codeword handshake bundle of the c499 SEC encoder.
interface c499_secenc_stream_if
  import c499_pkg::*;
();
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_inj_en;
  logic [5:0]        in_inj_pos;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CHK_W-1:0]  out_check;
  logic              out_enable;

  modport master (
    output in_valid, in_data, in_inj_en, in_inj_pos, out_ready,
    input  in_ready, out_valid, out_data, out_check, out_enable
  );

  modport slave (
    input  in_valid, in_data, in_inj_en, in_inj_pos, out_ready,
    output in_ready, out_valid, out_data, out_check, out_enable
  );
endinterface

// File: rtl/c499_chk_gen.sv
// Nibble parities (XOR of d[4j+3:4j]) and column parities (XOR of every
// fourth bit within each 16-bit half) feeding the check-bit combine.
module c499_chk_gen
  import c499_pkg::*;
(
  input  logic [DATA_W-1:0] data,
  output logic [7:0]        nib,
  output logic [7:0]        col
);
  for (genvar j = 0; j < 8; j++) begin : g_nib
    assign nib[j] = ^data[4*j +: 4];
  end

  for (genvar k = 0; k < 4; k++) begin : g_col
    assign col[k]   = data[k]    ^ data[k+4]  ^ data[k+8]  ^ data[k+12];
    assign col[k+4] = data[k+16] ^ data[k+20] ^ data[k+24] ^ data[k+28];
  end
endmodule

// File: rtl/c499_secenc_stream.sv
// Two-stage streaming SEC encoder: S1 registers partial parities, S2 combines
// them into check bits, applies the optional bit flip and drives the output.
// Build option C499_ENC_LOCK_EN adds key_0/key_1; a wrong key corrupts check[1].
module c499_secenc_stream
  import c499_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  c499_secenc_stream_if.slave  bus,
`ifdef C499_ENC_LOCK_EN
  input  logic                 key_0,
  input  logic                 key_1,
`endif
  output logic [CNT_W-1:0]     word_cnt,
  output logic [CNT_W-1:0]     inj_cnt
);
  localparam int STAGES = 2;

  logic [STAGES:1]  vld_pipe;
  logic             s1_adv, s2_adv;
  logic [7:0]       nib, col;
  s1_t              s1_d, s1_q;
  logic [CHK_W-1:0] chk;
  logic [CW_W-1:0]  flip;
  cw_t              cw_d, cw_q;
  logic             inj_d, inj_q;
  logic             key_ok;

`ifdef C499_ENC_LOCK_EN
  assign key_ok = key_0 & key_1;
`else
  assign key_ok = 1'b1;
`endif

  // Ready ripples back combinationally so a full pipe still moves one word per cycle.
  assign s2_adv       = !vld_pipe[2] || bus.out_ready;
  assign s1_adv       = !vld_pipe[1] || s2_adv;
  assign bus.in_ready = s1_adv;

  c499_chk_gen u_chk_gen (
    .data (bus.in_data),
    .nib  (nib),
    .col  (col)
  );

  always_comb begin
    s1_d         = '0;
    s1_d.data    = bus.in_data;
    s1_d.inj_en  = bus.in_inj_en;
    s1_d.inj_pos = bus.in_inj_pos;
    s1_d.nib     = nib;
    s1_d.col     = col;
  end

  always_comb begin
    chk[0] = s1_q.nib[4] ^ s1_q.nib[5] ^ s1_q.col[0];
    chk[1] = s1_q.nib[6] ^ s1_q.nib[7] ^ s1_q.col[1] ^ !key_ok;
    chk[2] = s1_q.nib[4] ^ s1_q.nib[6] ^ s1_q.col[2];
    chk[3] = s1_q.nib[5] ^ s1_q.nib[7] ^ s1_q.col[3];
    chk[4] = s1_q.nib[0] ^ s1_q.nib[1] ^ s1_q.col[4];
    chk[5] = s1_q.nib[2] ^ s1_q.nib[3] ^ s1_q.col[5];
    chk[6] = s1_q.nib[0] ^ s1_q.nib[2] ^ s1_q.col[6];
    chk[7] = s1_q.nib[1] ^ s1_q.nib[3] ^ s1_q.col[7];
    // Positions 40..63 name no codeword bit and are dropped silently.
    inj_d = s1_q.inj_en && (s1_q.inj_pos < 6'd40);
    flip  = '0;
    if (inj_d) flip = CW_W'(1) << s1_q.inj_pos;
    cw_d  = {chk, s1_q.data} ^ flip;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      s1_q     <= '0;
      cw_q     <= '0;
      inj_q    <= 1'b0;
    end else begin
      if (s1_adv) begin
        vld_pipe[1] <= bus.in_valid;
        if (bus.in_valid) s1_q <= s1_d;
      end
      if (s2_adv) begin
        vld_pipe[2] <= vld_pipe[1];
        if (vld_pipe[1]) begin
          cw_q  <= cw_d;
          inj_q <= inj_d;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      word_cnt <= '0;
      inj_cnt  <= '0;
    end else if (vld_pipe[2] && bus.out_ready) begin
      if (word_cnt != '1)        word_cnt <= word_cnt + 1'b1;
      if (inj_q && inj_cnt != '1) inj_cnt <= inj_cnt + 1'b1;
    end
  end

  assign bus.out_valid  = vld_pipe[2];
  assign bus.out_enable = vld_pipe[2];
  assign bus.out_data   = cw_q.data;
  assign bus.out_check  = cw_q.check;

endmodule

// File: tb/tb_c499_secenc_stream.sv
// Bench for c499_secenc_stream: vector table, random stream against a
// parity-rule reference, stall/reset/saturation sequences, optional key lock.
module tb_c499_secenc_stream;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [15:0] word_cnt, inj_cnt;
  logic [1:0]  word_cnt2, inj_cnt2;

  c499_secenc_stream_if bus ();
  c499_secenc_stream_if bus2 ();

`ifdef C499_ENC_LOCK_EN
  logic key_0 = 1'b1, key_1 = 1'b1;
`endif

  c499_secenc_stream #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .bus(bus),
`ifdef C499_ENC_LOCK_EN
    .key_0(key_0), .key_1(key_1),
`endif
    .word_cnt(word_cnt), .inj_cnt(inj_cnt)
  );

  // Narrow-counter instance so saturation is reachable in a few words.
  c499_secenc_stream #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2),
`ifdef C499_ENC_LOCK_EN
    .key_0(1'b1), .key_1(1'b1),
`endif
    .word_cnt(word_cnt2), .inj_cnt(inj_cnt2)
  );

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic par(input logic [31:0] d, input int a, input int b);
    logic p = 1'b0;
    for (int i = a; i <= b; i++) p ^= d[i];
    return p;
  endfunction

  // Check bits straight from the group-parity rules.
  function automatic logic [7:0] ref_check(input logic [31:0] d);
    logic [7:0] c;
    c[0] = par(d, 16, 23) ^ d[0] ^ d[4] ^ d[8]  ^ d[12];
    c[1] = par(d, 24, 31) ^ d[1] ^ d[5] ^ d[9]  ^ d[13];
    c[2] = par(d, 16, 19) ^ par(d, 24, 27) ^ d[2] ^ d[6] ^ d[10] ^ d[14];
    c[3] = par(d, 20, 23) ^ par(d, 28, 31) ^ d[3] ^ d[7] ^ d[11] ^ d[15];
    c[4] = par(d, 0, 7)   ^ d[16] ^ d[20] ^ d[24] ^ d[28];
    c[5] = par(d, 8, 15)  ^ d[17] ^ d[21] ^ d[25] ^ d[29];
    c[6] = par(d, 0, 3)   ^ par(d, 8, 11) ^ d[18] ^ d[22] ^ d[26] ^ d[30];
    c[7] = par(d, 4, 7)   ^ par(d, 12, 15) ^ d[19] ^ d[23] ^ d[27] ^ d[31];
    return c;
  endfunction

  function automatic logic [39:0] ref_cw(input logic [31:0] d, input logic inj,
                                         input int pos, input logic key_ok);
    logic [39:0] cw = {ref_check(d), d};
    if (!key_ok) cw[33] = ~cw[33];
    if (inj && pos < 40) cw[pos] = ~cw[pos];
    return cw;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Present one word, then wait (bounded) for its codeword.
  task automatic send_one(input logic [31:0] d, input logic inj, input logic [5:0] pos,
                          output logic [39:0] cw, output int lat);
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_data = d; bus.in_inj_en = inj; bus.in_inj_pos = pos;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = -1; cw = '0;
    for (int i = 1; i < 10; i++) begin
      #1;
      if (bus.out_valid) begin
        cw = {bus.out_check, bus.out_data};
        lat = i;
        break;
      end
      @(negedge clk);
    end
  endtask

  typedef struct {
    logic [31:0] d;
    logic        inj;
    logic [5:0]  pos;
    logic [31:0] exp_d;
    logic [7:0]  exp_c;
  } vec_t;

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    vec_t        tbl [7];
    logic [39:0] expq [$];
    logic [39:0] cw, e, prev_cw;
    logic [31:0] w [4];
    logic [31:0] pd;
    logic [5:0]  ppos;
    logic        pend, pinj, prev_stall;
    int          lat, n_sent, n_got, n_inj, acc, got;
    localparam int NW = 10000;

    tbl[0] = '{32'h0000_0000, 1'b0, 6'd0,  32'h0000_0000, 8'h00};
    tbl[1] = '{32'h0000_0001, 1'b0, 6'd0,  32'h0000_0001, 8'h51};
    tbl[2] = '{32'h0001_0000, 1'b0, 6'd0,  32'h0001_0000, 8'h15};
    tbl[3] = '{32'hFFFF_FFFF, 1'b0, 6'd0,  32'hFFFF_FFFF, 8'h00};
    tbl[4] = '{32'h0000_0000, 1'b1, 6'd35, 32'h0000_0000, 8'h08};
    tbl[5] = '{32'h0000_0000, 1'b1, 6'd7,  32'h0000_0080, 8'h00};
    tbl[6] = '{32'h0000_0000, 1'b1, 6'd45, 32'h0000_0000, 8'h00};

    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_inj_en = 1'b0; bus.in_inj_pos = '0;
    bus.out_ready = 1'b0;
    bus2.in_valid = 1'b0; bus2.in_data = '0; bus2.in_inj_en = 1'b0; bus2.in_inj_pos = '0;
    bus2.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_out_valid",  bus.out_valid, 1'b0);
    chk("rst_out_data",   bus.out_data, 32'h0);
    chk("rst_out_check",  bus.out_check, 8'h0);
    chk("rst_out_enable", bus.out_enable, 1'b0);
    chk("rst_word_cnt",   word_cnt, 16'h0);
    chk("rst_inj_cnt",    inj_cnt, 16'h0);
    chk("rst_in_ready",   bus.in_ready, 1'b1);

    // Back-to-back table: word c is presented in cycle c, its codeword in c+2.
    bus.out_ready = 1'b1;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      if (c < 7) begin
        bus.in_valid = 1'b1; bus.in_data = tbl[c].d;
        bus.in_inj_en = tbl[c].inj; bus.in_inj_pos = tbl[c].pos;
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      if (c < 7) chk($sformatf("tbl%0d_in_ready", c), bus.in_ready, 1'b1);
      if (c >= 2) begin
        chk($sformatf("tbl%0d_valid", c-2),  bus.out_valid, 1'b1);
        chk($sformatf("tbl%0d_enable", c-2), bus.out_enable, 1'b1);
        chk($sformatf("tbl%0d_data", c-2),   bus.out_data, tbl[c-2].exp_d);
        chk($sformatf("tbl%0d_check", c-2),  bus.out_check, tbl[c-2].exp_c);
      end else begin
        chk($sformatf("tbl_early_valid%0d", c), bus.out_valid, 1'b0);
      end
    end
    @(negedge clk); #1;
    chk("tbl_word_cnt", word_cnt, 16'd7);
    chk("tbl_inj_cnt",  inj_cnt, 16'd2);
    chk("tbl_drained",  bus.out_valid, 1'b0);

    // Saturation on the 2-bit counter instance: six injected words.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus2.in_valid = 1'b1; bus2.in_data = $urandom; bus2.in_inj_en = 1'b1; bus2.in_inj_pos = 6'd0;
    end
    @(negedge clk);
    bus2.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("sat_word_cnt", word_cnt2, 2'd3);
    chk("sat_inj_cnt",  inj_cnt2, 2'd3);

    // Random stream with random stalls against the reference codeword queue.
    do_reset();
    n_sent = 0; n_got = 0; n_inj = 0; pend = 1'b0; prev_stall = 1'b0; prev_cw = '0;
    pd = '0; pinj = 1'b0; ppos = '0;
    for (int cyc = 0; cyc < 40000 && n_got < NW; cyc++) begin
      @(negedge clk);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      if (!pend && n_sent < NW && $urandom_range(0, 3) != 0) begin
        pend = 1'b1; pd = $urandom; pinj = ($urandom_range(0, 3) == 0);
        ppos = 6'($urandom_range(0, 63));
      end
      bus.in_valid = pend;
      bus.in_data = pend ? pd : $urandom;
      bus.in_inj_en = pinj; bus.in_inj_pos = ppos;
      #1;
      if (prev_stall)
        chk("rnd_hold", {bus.out_valid, bus.out_check, bus.out_data}, {1'b1, prev_cw});
      if (bus.out_valid && bus.out_ready) begin
        if (expq.size() == 0) chk("rnd_extra_word", 1'b1, 1'b0);
        else begin
          e = expq.pop_front();
          chk($sformatf("rnd_cw%0d", n_got), {bus.out_check, bus.out_data}, e);
        end
        n_got++;
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_cw = {bus.out_check, bus.out_data};
      if (pend && bus.in_ready) begin
        expq.push_back(ref_cw(pd, pinj, int'(ppos), 1'b1));
        if (pinj && ppos < 6'd40) n_inj++;
        n_sent++;
        pend = 1'b0;
      end
    end
    bus.in_valid = 1'b0;
    chk("rnd_delivered", n_got, NW);
    @(negedge clk); #1;
    chk("rnd_word_cnt", word_cnt, NW);
    chk("rnd_inj_cnt",  inj_cnt, n_inj);

    // Backpressure: two words fill the pipe, then in_ready drops.
    do_reset();
    w[0] = 32'hDEAD_BEEF; w[1] = 32'h1234_5678; w[2] = 32'hA5A5_0F0F; w[3] = 32'h0BAD_F00D;
    acc = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      bus.out_ready = 1'b0;
      bus.in_valid = 1'b1; bus.in_data = w[acc]; bus.in_inj_en = 1'b0; bus.in_inj_pos = '0;
      #1;
      chk($sformatf("stall_in_ready%0d", c), bus.in_ready, (c < 2));
      if (c >= 2) begin
        chk($sformatf("stall_hold_valid%0d", c), bus.out_valid, 1'b1);
        chk($sformatf("stall_hold_cw%0d", c), {bus.out_check, bus.out_data},
            {ref_check(w[0]), w[0]});
      end
      if (bus.in_ready) acc++;
    end
    chk("stall_accepted", acc, 2);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    got = 0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      if (bus.out_valid) begin
        if (got < 2)
          chk($sformatf("stall_out%0d", got), {bus.out_check, bus.out_data},
              {ref_check(w[got]), w[got]});
        else
          chk("stall_duplicate", bus.out_valid, 1'b0);
        got++;
      end
      @(negedge clk); #1;
    end
    chk("stall_count", got, 2);
    chk("stall_word_cnt", word_cnt, 16'd2);

    // Reset with two words in flight.
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = 32'hCAFE_0001;
    @(negedge clk);
    bus.in_data = 32'hCAFE_0002;
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    chk("prerst_valid", bus.out_valid, 1'b1);
    rst = 1'b1;
    @(negedge clk); #1;
    chk("midrst_valid",    bus.out_valid, 1'b0);
    chk("midrst_word_cnt", word_cnt, 16'h0);
    chk("midrst_inj_cnt",  inj_cnt, 16'h0);
    rst = 1'b0;
    send_one(32'h0000_0001, 1'b0, 6'd0, cw, lat);
    chk("postrst_cw",  cw, {8'h51, 32'h0000_0001});
    chk("postrst_lat", lat, 2);
    @(negedge clk); #1;
    chk("postrst_word_cnt", word_cnt, 16'd1);
    chk("postrst_empty", bus.out_valid, 1'b0);

`ifdef C499_ENC_LOCK_EN
    for (int k = 0; k < 4; k++) begin
      key_0 = k[0]; key_1 = k[1];
      send_one(32'h0, 1'b0, 6'd0, cw, lat);
      chk($sformatf("lock_key%0d_check", k), cw[39:32], (k == 3) ? 8'h00 : 8'h02);
      chk($sformatf("lock_key%0d_data", k), cw[31:0], 32'h0);
    end
    key_0 = 1'b1; key_1 = 1'b1;
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
